// File: rtl/prio_arbiter_rr.sv
// Registered N-input arbiter, fixed-priority or round-robin, grant held until ack.
// Optional PRIO_ARBITER_STATS_EN adds gnt_count and idle_err outputs.
module prio_arbiter_rr #(
    parameter  int unsigned N = 8,
    localparam int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         mode,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_onehot
`ifdef PRIO_ARBITER_STATS_EN
    ,
    output logic [15:0]  gnt_count,
    output logic         idle_err
`endif
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   last, last_nxt;
    logic [W-1:0]   ptr;
    logic [W-1:0]   fixed_idx, rr_idx, win_idx;
    logic           rr_found;
    logic           valid_nxt;
    logic [W-1:0]   idx_nxt;
    logic [N-1:0]   onehot_nxt;
    int unsigned    cand;

    // An ack on this edge moves the pointer before the back-to-back arbitration.
    assign ptr = (state == GRANT && ack) ? gnt_idx : last;

    always_comb begin
        fixed_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i[W-1:0]]) fixed_idx = i[W-1:0];
        end
        rr_idx   = '0;
        rr_found = 1'b0;
        cand     = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= N) cand = cand - N;
            if (!rr_found && req[cand[W-1:0]]) begin
                rr_idx   = cand[W-1:0];
                rr_found = 1'b1;
            end
        end
        win_idx = mode ? rr_idx : fixed_idx;
    end

    always_comb begin
        state_nxt  = state;
        last_nxt   = last;
        valid_nxt  = gnt_valid;
        idx_nxt    = gnt_idx;
        onehot_nxt = gnt_onehot;
        unique case (state)
            IDLE: begin
                if (en && (req != '0)) begin
                    state_nxt  = GRANT;
                    valid_nxt  = 1'b1;
                    idx_nxt    = win_idx;
                    onehot_nxt = N'(1) << win_idx;
                end else begin
                    valid_nxt  = 1'b0;
                    idx_nxt    = '0;
                    onehot_nxt = '0;
                end
            end
            GRANT: begin
                if (ack) begin
                    last_nxt = gnt_idx;
                    if (en && (req != '0)) begin
                        valid_nxt  = 1'b1;
                        idx_nxt    = win_idx;
                        onehot_nxt = N'(1) << win_idx;
                    end else begin
                        state_nxt  = IDLE;
                        valid_nxt  = 1'b0;
                        idx_nxt    = '0;
                        onehot_nxt = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last       <= W'(N - 1);
            gnt_valid  <= 1'b0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
        end else begin
            state      <= state_nxt;
            last       <= last_nxt;
            gnt_valid  <= valid_nxt;
            gnt_idx    <= idx_nxt;
            gnt_onehot <= onehot_nxt;
        end
    end

`ifdef PRIO_ARBITER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_count <= '0;
            idle_err  <= 1'b0;
        end else begin
            idle_err <= (state == IDLE) && ack;
            if ((state == GRANT) && ack && (gnt_count != '1))
                gnt_count <= gnt_count + 16'd1;
        end
    end
`else
    // Core only: no statistics state.
`endif

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Directed self-checking bench for prio_arbiter_rr (N=8).
// Define PRIO_ARBITER_STATS_EN to also exercise the statistics outputs.
module tb_prio_arbiter_rr;

    localparam int unsigned N = 8;
    localparam int unsigned W = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         mode;
    logic [N-1:0] req;
    logic         ack;
    logic         gnt_valid;
    logic [W-1:0] gnt_idx;
    logic [N-1:0] gnt_onehot;
`ifdef PRIO_ARBITER_STATS_EN
    logic [15:0]  gnt_count;
    logic         idle_err;
`endif

    int checks = 0;
    int errors = 0;

    prio_arbiter_rr #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .req        (req),
        .ack        (ack),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot)
`ifdef PRIO_ARBITER_STATS_EN
        ,
        .gnt_count  (gnt_count),
        .idle_err   (idle_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_gnt(input string tag, input logic v, input logic [W-1:0] idx,
                           input logic [N-1:0] oh);
        chk({tag, ".valid"},  32'(gnt_valid),  32'(v));
        chk({tag, ".idx"},    32'(gnt_idx),    32'(idx));
        chk({tag, ".onehot"}, 32'(gnt_onehot), 32'(oh));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; req = '0; ack = 1'b0;
        #2;
        chk_gnt("reset", 1'b0, 3'd0, 8'h00);
        tick();
        rst_n = 1'b1;

        // 1: fixed priority, highest set bit wins; grant frozen without ack
        en = 1'b1; mode = 1'b0; req = 8'b0010_0110;
        tick();
        chk_gnt("fixed_win", 1'b1, 3'd5, 8'h20);
        req = '0; en = 1'b0; mode = 1'b1;
        repeat (10) tick();
        chk_gnt("hold_no_ack", 1'b1, 3'd5, 8'h20);
        en = 1'b1; mode = 1'b0; ack = 1'b1;
        tick();
        chk_gnt("ack_to_idle", 1'b0, 3'd0, 8'h00);
        ack = 1'b0;

        // 2: round-robin from reset, all requesting, ack every cycle
        do_reset();
        mode = 1'b1; req = 8'hFF; en = 1'b1;
        tick();
        chk_gnt("rr_first", 1'b1, 3'd0, 8'h01);
        ack = 1'b1;
        for (int unsigned k = 1; k <= 9; k++) begin
            tick();
            chk_gnt($sformatf("rr_seq%0d", k), 1'b1, 3'(k % N), 8'(1 << (k % N)));
        end
        req = '0;
        tick();
        chk_gnt("rr_drain", 1'b0, 3'd0, 8'h00);
        ack = 1'b0;

        // 3: pointer at 3, req 0b1001 -> 0, then 3
        mode = 1'b0; req = 8'h08;
        tick();
        chk_gnt("set_ptr3", 1'b1, 3'd3, 8'h08);
        mode = 1'b1; req = 8'b0000_1001; ack = 1'b1;
        tick();
        chk_gnt("rr_wrap0", 1'b1, 3'd0, 8'h01);
        tick();
        chk_gnt("rr_next3", 1'b1, 3'd3, 8'h08);
        req = '0;
        tick();
        chk_gnt("rr3_drain", 1'b0, 3'd0, 8'h00);
        ack = 1'b0;

        // 4: enable gates only new grants
        en = 1'b0; req = 8'h10;
        tick(); tick();
        chk_gnt("en_off_idle", 1'b0, 3'd0, 8'h00);
        en = 1'b1;
        tick();
        chk_gnt("en_on_grant", 1'b1, 3'd4, 8'h10);
        en = 1'b0;
        tick();
        chk_gnt("en_off_held", 1'b1, 3'd4, 8'h10);
        ack = 1'b1;
        tick();
        chk_gnt("en_off_ack", 1'b0, 3'd0, 8'h00);
        ack = 1'b0;

        // 5: asynchronous reset mid-grant
        en = 1'b1; mode = 1'b0; req = 8'h40;
        tick();
        chk_gnt("pre_reset", 1'b1, 3'd6, 8'h40);
        #2 rst_n = 1'b0;
        #1;
        chk_gnt("async_reset", 1'b0, 3'd0, 8'h00);
        tick();
        rst_n = 1'b1;
        mode = 1'b1; req = 8'hFF;
        tick();
        chk_gnt("post_reset_rr", 1'b1, 3'd0, 8'h01);

        // single requester always wins, even right after being acked
        req = 8'h04; ack = 1'b1;
        tick();
        chk_gnt("single_a", 1'b1, 3'd2, 8'h04);
        tick();
        chk_gnt("single_b", 1'b1, 3'd2, 8'h04);
        req = '0;
        tick();
        ack = 1'b0;

`ifdef PRIO_ARBITER_STATS_EN
        do_reset();
        chk("cnt_reset", 32'(gnt_count), 32'd0);
        mode = 1'b0; en = 1'b1; req = 8'h01;
        tick();
        ack = 1'b1;
        tick(); tick();
        req = '0;
        tick();
        chk("cnt_three", 32'(gnt_count), 32'd3);
        chk("err_quiet", 32'(idle_err), 32'd0);
        tick();
        chk("idle_err_set", 32'(idle_err), 32'd1);
        chk("cnt_unchanged", 32'(gnt_count), 32'd3);
        ack = 1'b0;
        tick();
        chk("idle_err_pulse", 32'(idle_err), 32'd0);
        req = 8'hFF; ack = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        chk("cnt_saturate", 32'(gnt_count), 32'h0000_FFFF);
        ack = 1'b0; req = '0;
`else
        chk("no_stats_idle", 32'(gnt_valid), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prio_arbiter_rr.md
Name:
prio_arbiter_rr

Overview:
- Parametrised, registered N-input priority encoder/arbiter; the sequential successor of the team's 4-to-2 combinational priority encoder.
- Selects one active request and presents it as a binary index plus a one-hot grant.
- Holds the grant until the consumer acknowledges it.
- Two selection modes, chosen at run time: fixed priority (highest index wins, same ordering as the existing encoder) and round-robin.
- Sits between multiple requesters and a shared resource, e.g. a bus or a shared register port.

Parameters:
- N, 8, number of request lines; legal range 2..32.
- W, $clog2(N), width of the grant index; derived, never overridden.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, arbitration enable; gates new grants only.
- mode, input, 1, 0 = fixed priority (index N-1 highest), 1 = round-robin.
- req, input, N, request vector; bit i = requester i.
- ack, input, 1, consumer accepts the current grant.
- gnt_valid, output, 1, a grant is being presented.
- gnt_idx, output, W, binary index of the granted requester.
- gnt_onehot, output, N, one-hot form of gnt_idx; all zero when gnt_valid=0.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - gnt_valid=0, gnt_idx=0, gnt_onehot=0.
  - Round-robin pointer last=N-1.
  - FSM in IDLE.
  - Reset takes effect mid-grant with no completion.
- FSM states: IDLE and GRANT.
- IDLE:
  - If en=1 and req!=0, compute the winner, register gnt_idx/gnt_onehot, set gnt_valid=1 and go to GRANT.
  - Latency: request sampled at edge k, grant visible after edge k, i.e. one cycle.
  - Otherwise stay in IDLE with outputs at 0.
- GRANT:
  - Outputs stay frozen, even if req[gnt_idx] drops, en drops or mode changes.
  - On ack=1: last <= gnt_idx.
  - Same edge, back-to-back case: if en=1 and req!=0, arbitrate again using the updated pointer and stay in GRANT with the new winner. No bubble.
  - Same edge, no new request: otherwise clear the outputs and go to IDLE.
- ack in IDLE is ignored.
- Fixed mode winner: highest set bit of req.
- Round-robin winner: first set bit searching upward from index last+1, wrapping modulo N. The last granted requester gets lowest priority.
- The pointer updates on every ack, in both modes. A switch to round-robin therefore continues from the most recently acknowledged index.
- mode and req are sampled only at the arbitration edge.
- Single requester: that requester always wins, in either mode.
- All-ones req in round-robin: grant order rotates 0,1,...,N-1,0 when starting from reset.
- Invariants:
  - gnt_onehot == (1<<gnt_idx) whenever gnt_valid=1.
  - gnt_onehot == 0 otherwise.
  - gnt_valid never drops without ack or reset.

Optional Feature:
- Macro: PRIO_ARBITER_STATS_EN.
- With the macro defined:
  - Extra output gnt_count, 16 bits, reset to 0.
  - Increments on each accepted grant (ack=1 in GRANT).
  - Saturates at 16'hFFFF.
  - Extra output idle_err, 1 bit, a registered pulse lasting one cycle when ack=1 arrives in IDLE. Reset value 0.
- Without the macro: neither port exists and there is no counter logic. Core behaviour is identical.

Test Plan:
1. N=8, mode=0, en=1, req=8'b0010_0110 -> one cycle later gnt_valid=1, gnt_idx=5, gnt_onehot=8'h20. Held with no ack for 10 cycles and req dropped to 0 -> outputs unchanged.
2. mode=1 from reset, req=8'hFF held, ack=1 every cycle -> gnt_idx sequence 0,1,2,...,7,0,1 with gnt_valid constantly 1 (no bubbles).
3. mode=1, last=3 (after acking index 3), req=8'b0000_1001 -> gnt_idx=0. Ack, then req=8'b0000_1001 again -> gnt_idx=3.
4. en=0 with req=8'h10 -> gnt_valid stays 0. en=1 -> grant idx 4 one cycle later. en=0 during GRANT -> grant held. ack -> IDLE, gnt_valid=0.
5. Grant active at idx 6, rst_n pulsed low mid-cycle -> all outputs 0 immediately, before the next clock edge. After release, mode=1 with req=8'hFF -> gnt_idx=0.
6. PRIO_ARBITER_STATS_EN defined: 3 acked grants -> gnt_count=3. ack while IDLE -> idle_err=1 for one cycle, gnt_count unchanged. Preload 65535 acks -> count stays 16'hFFFF.
